// File: rtl/cpu_mailbox_pkg.sv
// Shared types and mailbox layout for the CPU run controller.
package cpu_mailbox_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRelease,
    StRun,
    StDone,
    StTimeout
  } mboxStateT;

  // Byte offsets of the mailbox words relative to the mailbox base.
  localparam logic [31:0] OFF_START = 32'h0000_0000;
  localparam logic [31:0] OFF_END   = 32'h0000_0004;
  localparam logic [31:0] OFF_NODE  = 32'h0000_0008;
  localparam logic [31:0] OFF_DONE  = 32'h0000_000C;

  localparam logic [31:0] MBOX_BASE_DFLT = 32'h0200_0000;

endpackage

// File: rtl/run_watchdog.sv
// Run-state cycle budget: counts while enabled, flags the last permitted cycle.
module run_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cntQ;

  // Counter restarts from zero whenever the run is not active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cntQ <= '0;
    end else if (clear) begin
      cntQ <= '0;
    end else if (enable && !terminal) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign terminal = enable && (cntQ == LastCnt);

endmodule

// File: rtl/cpu_mailbox_ctrl.sv
// Sequences a CPU run: preload mailbox, release reset, snoop node/done writes.
module cpu_mailbox_ctrl
  import cpu_mailbox_pkg::*;
#(
  parameter logic [31:0] MBOX_BASE      = MBOX_BASE_DFLT,
  parameter int unsigned MAX_NODES      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  start_point,
  input  logic [4:0]  end_point,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic [31:0] DataAdr,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        node_valid,
  output logic [4:0]  node_data,
  output logic [5:0]  node_count,
  output logic        node_ovf
);

  localparam logic [5:0] MaxCount = 6'(MAX_NODES);

  mboxStateT   stateQ, stateD;
  logic [1:0]  loadIdxQ;
  logic [4:0]  startPointQ, endPointQ;
  logic [5:0]  nodeCountQ;
  logic        nodeOvfQ, nodeValidQ;
  logic [4:0]  nodeDataQ;
  logic        wdTerminal;
  logic        startAcc, nodeHit, doneHit, inRun;

  assign inRun    = (stateQ == StRun);
  assign startAcc = start &&
                    ((stateQ == StIdle) || (stateQ == StDone) || (stateQ == StTimeout));
  assign nodeHit  = inRun && MemWrite && (DataAdr == MBOX_BASE + OFF_NODE);
  assign doneHit  = inRun && MemWrite && (DataAdr == MBOX_BASE + OFF_DONE) &&
                    (WriteData == 32'd1);

  run_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_run_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!inRun),
    .enable  (inRun),
    .terminal(wdTerminal)
  );

  // Next-state: completion beats the watchdog when both land on the same edge.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle, StDone, StTimeout: if (start) stateD = StLoad;
      StLoad:                    if (loadIdxQ == 2'd3) stateD = StRelease;
      StRelease:                 stateD = StRun;
      StRun: begin
        if (doneHit) begin
          stateD = StDone;
        end else if (wdTerminal) begin
          stateD = StTimeout;
        end
      end
      default:                   stateD = StIdle;
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    cpu_reset     = 1'b1;
    Ext_MemWrite  = 1'b0;
    Ext_WriteData = '0;
    Ext_DataAdr   = '0;
    busy          = 1'b0;
    done          = 1'b0;
    timeout       = 1'b0;
    unique case (stateQ)
      StLoad: begin
        busy         = 1'b1;
        Ext_MemWrite = 1'b1;
        Ext_DataAdr  = MBOX_BASE + {28'b0, loadIdxQ, 2'b00};
        if (loadIdxQ == 2'd0) begin
          Ext_WriteData = {27'b0, startPointQ};
        end else if (loadIdxQ == 2'd1) begin
          Ext_WriteData = {27'b0, endPointQ};
        end
      end
      StRelease: busy = 1'b1;
      StRun: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
      end
      StDone:    done = 1'b1;
      StTimeout: timeout = 1'b1;
      default: ;
    endcase
  end

  // State, preload index and latched points.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ      <= StIdle;
      loadIdxQ    <= '0;
      startPointQ <= '0;
      endPointQ   <= '0;
    end else begin
      stateQ <= stateD;
      if (startAcc) begin
        loadIdxQ    <= '0;
        startPointQ <= start_point;
        endPointQ   <= end_point;
      end else if (stateQ == StLoad) begin
        loadIdxQ <= loadIdxQ + 2'd1;
      end
    end
  end

  // Node event stream; overflowing nodes still pulse but leave the count saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nodeValidQ <= 1'b0;
      nodeDataQ  <= '0;
      nodeCountQ <= '0;
      nodeOvfQ   <= 1'b0;
    end else begin
      nodeValidQ <= nodeHit;
      if (nodeHit) begin
        nodeDataQ <= WriteData[4:0];
      end
      if (startAcc) begin
        nodeCountQ <= '0;
        nodeOvfQ   <= 1'b0;
      end else if (nodeHit) begin
        if (nodeCountQ < MaxCount) begin
          nodeCountQ <= nodeCountQ + 6'd1;
        end else begin
          nodeOvfQ <= 1'b1;
        end
      end
    end
  end

  assign node_valid = nodeValidQ;
  assign node_data  = nodeDataQ;
  assign node_count = nodeCountQ;
  assign node_ovf   = nodeOvfQ;

endmodule

// File: tb/tb_cpu_mailbox_ctrl.sv
// Self-checking bench for cpu_mailbox_ctrl: directed scenarios plus a random run
// checked against a cycle-count based reference model.
module tb_cpu_mailbox_ctrl;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [5:0]  MAXN = 6'd3;
  localparam int          TO   = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  start_point, end_point;
  logic        cpu_reset, Ext_MemWrite;
  logic [31:0] Ext_WriteData, Ext_DataAdr;
  logic        MemWrite;
  logic [31:0] WriteData, DataAdr;
  logic        busy, done, timeout, node_valid, node_ovf;
  logic [4:0]  node_data;
  logic [5:0]  node_count;

  int total = 0;
  int bad   = 0;

  // Reference model: progress measured as edges since the accepted start.
  bit         mActive, mNodeValid, mOvf;
  int         mEnd;  // 0 running/idle, 1 done, 2 timeout
  int         mK;
  logic [4:0] mSp, mEp, mNodeData;
  logic [5:0] mCount;

  cpu_mailbox_ctrl #(
    .MBOX_BASE     (BASE),
    .MAX_NODES     (3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_point  (start_point),
    .end_point    (end_point),
    .cpu_reset    (cpu_reset),
    .Ext_MemWrite (Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr  (Ext_DataAdr),
    .MemWrite     (MemWrite),
    .WriteData    (WriteData),
    .DataAdr      (DataAdr),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .node_valid   (node_valid),
    .node_data    (node_data),
    .node_count   (node_count),
    .node_ovf     (node_ovf)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    mActive = 0; mEnd = 0; mK = 0; mSp = '0; mEp = '0;
    mNodeValid = 0; mNodeData = '0; mCount = '0; mOvf = 0;
  endfunction

  function automatic void modelEdge();
    bit live;
    if (reset) begin
      modelReset();
      return;
    end
    live = mActive && (mEnd == 0);
    mNodeValid = 0;
    if (!live) begin
      if (start) begin
        mActive = 1; mEnd = 0; mK = 0; mSp = start_point; mEp = end_point;
        mCount = '0; mOvf = 0;
      end
    end else begin
      if (mK >= 5) begin
        if (MemWrite && DataAdr == BASE + 32'd8) begin
          mNodeValid = 1;
          mNodeData  = WriteData[4:0];
          if (mCount < MAXN) mCount = mCount + 6'd1;
          else mOvf = 1;
        end
        if (MemWrite && DataAdr == BASE + 32'd12 && WriteData == 32'd1) mEnd = 1;
        else if (mK - 5 == TO - 1) mEnd = 2;
      end
      mK++;
    end
  endfunction

  function automatic logic [81:0] modelOut();
    logic        load, rel, run;
    logic [31:0] adr, wd;
    load = mActive && mEnd == 0 && mK <= 3;
    rel  = mActive && mEnd == 0 && mK == 4;
    run  = mActive && mEnd == 0 && mK >= 5;
    adr  = load ? BASE + 32'(4 * mK) : 32'd0;
    wd   = !load ? 32'd0 : (mK == 0) ? {27'd0, mSp} : (mK == 1) ? {27'd0, mEp} : 32'd0;
    return {!run, load, wd, adr, load || rel || run, mActive && mEnd == 1,
            mActive && mEnd == 2, mNodeValid, mNodeData, mCount, mOvf};
  endfunction

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic busIdle();
    MemWrite = 0; DataAdr = '0; WriteData = '0;
  endtask

  task automatic doReset();
    reset = 1; start = 0; start_point = '0; end_point = '0;
    busIdle();
    #1;
    modelReset();
    tick();
    reset = 0;
  endtask

  // Start a run and advance to the first RUN cycle (after E5).
  task automatic runTo(input logic [4:0] sp, input logic [4:0] ep);
    start = 1; start_point = sp; end_point = ep;
    tick();
    start = 0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    logic [81:0] want;
    want = {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0};
    reset = 1; start = 0; busIdle();
    #1;
    total++;
    if ({cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr, busy, done, timeout,
         node_valid, node_data, node_count, node_ovf} !== want) begin
      bad++; $display("FAIL reset_values got=%h want=%h", {cpu_reset, Ext_MemWrite,
        Ext_WriteData, Ext_DataAdr, busy, done, timeout, node_valid, node_data,
        node_count, node_ovf}, want);
    end
    doReset();
    tick();
    total++;
    if ({cpu_reset, Ext_MemWrite, busy, done, timeout} !== 5'b10000) begin
      bad++; $display("FAIL idle_after_reset got=%b want=10000",
                      {cpu_reset, Ext_MemWrite, busy, done, timeout});
    end
  endtask

  task automatic test_load_sequence();
    logic [31:0] wantD [4];
    wantD[0] = 32'd3; wantD[1] = 32'd14; wantD[2] = 32'd0; wantD[3] = 32'd0;
    doReset();
    start = 1; start_point = 5'd3; end_point = 5'd14;
    tick();
    start = 0; start_point = 5'd0; end_point = 5'd0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({Ext_MemWrite, Ext_DataAdr, Ext_WriteData, cpu_reset, busy} !==
          {1'b1, BASE + 32'(4 * i), wantD[i], 1'b1, 1'b1}) begin
        bad++; $display("FAIL load_word[%0d] got we=%b adr=%h data=%h want adr=%h data=%h",
                        i, Ext_MemWrite, Ext_DataAdr, Ext_WriteData, BASE + 32'(4 * i), wantD[i]);
      end
      tick();
    end
    total++;
    if ({Ext_MemWrite, Ext_DataAdr, Ext_WriteData, cpu_reset, busy} !== {1'b0, 64'd0, 2'b11}) begin
      bad++; $display("FAIL release_cycle got we=%b adr=%h cpu_reset=%b want we=0 adr=0 cpu_reset=1",
                      Ext_MemWrite, Ext_DataAdr, cpu_reset);
    end
    tick();
    total++;
    if ({cpu_reset, busy} !== 2'b01) begin
      bad++; $display("FAIL cpu_release got cpu_reset=%b busy=%b want 0 1", cpu_reset, busy);
    end
  endtask

  task automatic test_node_stream();
    logic [4:0] vals [3];
    vals[0] = 5'd3; vals[1] = 5'd7; vals[2] = 5'd14;
    doReset();
    runTo(5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      MemWrite = 1; DataAdr = BASE + 32'd8; WriteData = ($urandom & 32'hFFFF_FFE0) | {27'd0, vals[i]};
      tick();
      busIdle();
      total++;
      if ({node_valid, node_data, node_count} !== {1'b1, vals[i], 6'(i + 1)}) begin
        bad++; $display("FAIL node_pulse[%0d] got v=%b d=%0d cnt=%0d want v=1 d=%0d cnt=%0d",
                        i, node_valid, node_data, node_count, vals[i], i + 1);
      end
      tick();
      total++;
      if (node_valid !== 1'b0) begin
        bad++; $display("FAIL node_pulse_end[%0d] got=%b want=0", i, node_valid);
      end
      tick();
    end
    MemWrite = 1; DataAdr = BASE + 32'hC; WriteData = 32'd1;
    tick();
    busIdle();
    total++;
    if ({done, timeout, cpu_reset, busy, node_count} !== {4'b1010, 6'd3}) begin
      bad++; $display("FAIL run_done got done=%b to=%b cpu_reset=%b busy=%b cnt=%0d want 1 0 1 0 3",
                      done, timeout, cpu_reset, busy, node_count);
    end
  endtask

  task automatic test_filtering();
    doReset();
    start = 1; start_point = 5'd4; end_point = 5'd9;
    tick();
    start = 0;
    // Node and done writes across LOAD and the RELEASE edge must be ignored.
    for (int i = 1; i <= 5; i++) begin
      MemWrite = 1;
      DataAdr  = (i == 3) ? BASE + 32'hC : BASE + 32'd8;
      WriteData = (i == 3) ? 32'd1 : 32'd5;
      tick();
      total++;
      if (node_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL preload_bus_ignored[%0d] got v=%b done=%b busy=%b want 0 0 1",
                        i, node_valid, done, busy);
      end
    end
    busIdle();
    for (int i = 0; i < 3; i++) begin
      MemWrite  = (i != 2);
      DataAdr   = (i == 0) ? BASE + 32'hC : (i == 1) ? BASE + 32'h10 : BASE + 32'd8;
      WriteData = (i == 0) ? 32'd0 : 32'd1;
      tick();
      total++;
      if ({node_valid, done, busy, cpu_reset} !== 4'b0010) begin
        bad++; $display("FAIL run_bus_ignored[%0d] got v=%b done=%b busy=%b cpu_reset=%b want 0 0 1 0",
                        i, node_valid, done, busy, cpu_reset);
      end
    end
    busIdle();
    total++;
    if (node_count !== 6'd0) begin
      bad++; $display("FAIL filtered_count got=%0d want=0", node_count);
    end
  endtask

  task automatic test_watchdog();
    doReset();
    runTo(5'd2, 5'd3);
    repeat (TO - 1) tick();
    total++;
    if ({timeout, cpu_reset, busy} !== 3'b001) begin
      bad++; $display("FAIL wd_last_cycle got to=%b cpu_reset=%b busy=%b want 0 0 1",
                      timeout, cpu_reset, busy);
    end
    tick();
    total++;
    if ({timeout, done, cpu_reset, busy} !== 4'b1010) begin
      bad++; $display("FAIL wd_expire got to=%b done=%b cpu_reset=%b busy=%b want 1 0 1 0",
                      timeout, done, cpu_reset, busy);
    end
    start = 1; start_point = 5'd17;
    tick();
    start = 0;
    total++;
    if ({timeout, Ext_MemWrite, Ext_WriteData} !== {2'b01, 32'd17}) begin
      bad++; $display("FAIL restart_from_timeout got to=%b we=%b data=%h want 0 1 00000011",
                      timeout, Ext_MemWrite, Ext_WriteData);
    end
    // DONE on the final permitted cycle wins over the watchdog.
    doReset();
    runTo(5'd2, 5'd3);
    repeat (TO - 1) tick();
    MemWrite = 1; DataAdr = BASE + 32'hC; WriteData = 32'd1;
    tick();
    busIdle();
    total++;
    if ({done, timeout} !== 2'b10) begin
      bad++; $display("FAIL done_beats_wd got done=%b to=%b want 1 0", done, timeout);
    end
  endtask

  task automatic test_overflow_restart();
    doReset();
    runTo(5'd6, 5'd8);
    for (int i = 0; i < 5; i++) begin
      MemWrite = 1; DataAdr = BASE + 32'd8; WriteData = 32'(20 + i);
      tick();
      total++;
      if ({node_valid, node_data, node_count, node_ovf} !==
          {1'b1, 5'(20 + i), (i < 3) ? 6'(i + 1) : MAXN, (i >= 3)}) begin
        bad++; $display("FAIL ovf_pulse[%0d] got v=%b d=%0d cnt=%0d ovf=%b want v=1 d=%0d cnt=%0d ovf=%0d",
                        i, node_valid, node_data, node_count, node_ovf, 20 + i,
                        (i < 3) ? i + 1 : 3, i >= 3);
      end
    end
    DataAdr = BASE + 32'hC; WriteData = 32'd1;
    tick();
    busIdle();
    start = 1; start_point = 5'd9; end_point = 5'd21;
    tick();
    start = 0;
    total++;
    if ({done, node_count, node_ovf, Ext_MemWrite, Ext_DataAdr, Ext_WriteData} !==
        {1'b0, 6'd0, 1'b0, 1'b1, BASE, 32'd9}) begin
      bad++; $display("FAIL restart_clear got done=%b cnt=%0d ovf=%b we=%b adr=%h data=%h",
                      done, node_count, node_ovf, Ext_MemWrite, Ext_DataAdr, Ext_WriteData);
    end
  endtask

  task automatic test_mid_run_reset();
    doReset();
    runTo(5'd1, 5'd1);
    start = 1; start_point = 5'd30;
    tick();
    start = 0;
    total++;
    if ({Ext_MemWrite, cpu_reset, busy} !== 3'b001) begin
      bad++; $display("FAIL start_ignored_run got we=%b cpu_reset=%b busy=%b want 0 0 1",
                      Ext_MemWrite, cpu_reset, busy);
    end
    reset = 1;
    #1;
    total++;
    if ({Ext_MemWrite, cpu_reset, busy} !== 3'b010) begin
      bad++; $display("FAIL reset_in_run got we=%b cpu_reset=%b busy=%b want 0 1 0",
                      Ext_MemWrite, cpu_reset, busy);
    end
    doReset();
    start = 1; start_point = 5'd11;
    tick();
    start_point = 5'd2;  // held high while busy: must not restart the preload
    tick();
    tick();
    total++;
    if ({Ext_MemWrite, Ext_DataAdr} !== {1'b1, BASE + 32'd8}) begin
      bad++; $display("FAIL load_index2 got we=%b adr=%h want 1 %h", Ext_MemWrite, Ext_DataAdr,
                      BASE + 32'd8);
    end
    start = 0;
    reset = 1;
    #1;
    total++;
    if ({Ext_MemWrite, Ext_DataAdr, cpu_reset, busy} !== {1'b0, 32'd0, 2'b10}) begin
      bad++; $display("FAIL reset_in_load got we=%b adr=%h cpu_reset=%b busy=%b",
                      Ext_MemWrite, Ext_DataAdr, cpu_reset, busy);
    end
    doReset();
  endtask

  task automatic test_random();
    int pick;
    logic [81:0] got;
    doReset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 19) == 0);
      start_point = 5'($urandom);
      end_point   = 5'($urandom);
      MemWrite = $urandom_range(0, 1) == 1;
      pick = $urandom_range(0, 5);
      DataAdr = (pick == 5) ? $urandom : BASE + 32'(4 * pick);
      if (pick == 3) WriteData = ($urandom_range(0, 5) == 0) ? 32'd1 : 32'($urandom_range(0, 3));
      else WriteData = $urandom;
      tick();
      got = {cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr, busy, done, timeout,
             node_valid, node_data, node_count, node_ovf};
      total++;
      if (got !== modelOut()) begin
        bad++; $display("FAIL random_cycle[%0d] got=%h want=%h", c, got, modelOut());
      end
    end
    reset = 0;
    busIdle();
  endtask

  initial begin
    reset = 1; start = 0; start_point = '0; end_point = '0;
    busIdle();
    modelReset();
    test_reset();
    test_load_sequence();
    test_node_stream();
    test_filtering();
    test_watchdog();
    test_overflow_restart();
    test_mid_run_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
